branch_resolve_unit: RTL

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves RV32I JAL/JALR/BRANCH into redirect, link and flush results.
// Optional return-address stack is compiled in when BRU_RAS_EN is defined.
module branch_resolve_unit #(
    parameter int NB_WORD      = 32,
    parameter int NB_ADDR      = 32,
    parameter int NB_OPERAND   = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int RAS_DEPTH    = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [NB_ADDR-1:0]    i_pc,
    input  logic [NB_WORD-1:0]    i_instruction,
    input  logic [NB_WORD-1:0]    i_op1,
    input  logic [NB_WORD-1:0]    i_op2,
    output logic                  o_valid,
    output logic                  o_branch_taken,
    output logic [NB_ADDR-1:0]    o_branch_addr,
    output logic [NB_ADDR-1:0]    o_ret_addr,
    output logic                  o_wr_retaddr,
    output logic [NB_OPERAND-1:0] o_rd_retaddr,
    output logic                  o_flush,
    output logic                  o_misaligned,
    output logic                  o_ras_hit
);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [4:0]         rd;
    logic [NB_ADDR-1:0] imm_j;
    logic [NB_ADDR-1:0] imm_b;
    logic [NB_ADDR-1:0] imm_i;
    logic [NB_ADDR-1:0] jalr_sum;
    logic [NB_ADDR-1:0] target;
    logic [NB_ADDR-1:0] link;
    logic               is_jal;
    logic               is_jalr;
    logic               is_branch;
    logic               cond;
    logic               taken_raw;
    logic               take_ok;
    logic               accept;
    logic               ras_hit_d;
    logic [3:0]         flush_cnt;

    assign o_ready = (flush_cnt == 4'd0);
    assign o_flush = (flush_cnt != 4'd0);
    assign accept  = i_valid && o_ready;

    always_comb begin
        opcode    = i_instruction[6:0];
        funct3    = i_instruction[14:12];
        rd        = i_instruction[11:7];
        is_jal    = (opcode == OP_JAL);
        is_jalr   = (opcode == OP_JALR);
        is_branch = (opcode == OP_BRANCH);
        imm_j = {{(NB_ADDR-21){i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                 i_instruction[20], i_instruction[30:21], 1'b0};
        imm_b = {{(NB_ADDR-13){i_instruction[31]}}, i_instruction[31], i_instruction[7],
                 i_instruction[30:25], i_instruction[11:8], 1'b0};
        imm_i = {{(NB_ADDR-12){i_instruction[31]}}, i_instruction[31:20]};
        jalr_sum = i_op1[NB_ADDR-1:0] + imm_i;
        link     = i_pc + NB_ADDR'(4);
        case (funct3)
            3'b000:  cond = (i_op1 == i_op2);
            3'b001:  cond = (i_op1 != i_op2);
            3'b100:  cond = ($signed(i_op1) < $signed(i_op2));
            3'b101:  cond = ($signed(i_op1) >= $signed(i_op2));
            3'b110:  cond = (i_op1 < i_op2);
            3'b111:  cond = (i_op1 >= i_op2);
            default: cond = 1'b0;
        endcase
        if (is_jalr) begin
            target = {jalr_sum[NB_ADDR-1:1], 1'b0};
        end else if (is_jal) begin
            target = i_pc + imm_j;
        end else begin
            target = i_pc + imm_b;
        end
        taken_raw = is_jal || is_jalr || (is_branch && cond);
        // A misaligned target is reported but never redirects or links.
        take_ok   = taken_raw && !target[1];
    end

`ifdef BRU_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NB_ADDR-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]   ras_ptr;
    logic [PTR_W-1:0]   top_idx;
    logic [PTR_W-1:0]   ptr_after_pop;
    logic [CNT_W-1:0]   ras_cnt;
    logic [CNT_W-1:0]   cnt_after_pop;
    logic [4:0]         rs1;
    logic               rd_link;
    logic               rs1_link;
    logic               ras_push;
    logic               ras_pop;
    logic               pop_live;

    always_comb begin
        rs1      = i_instruction[19:15];
        rd_link  = (rd == 5'd1) || (rd == 5'd5);
        rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
        ras_push = accept && take_ok && (is_jal || is_jalr) && rd_link;
        ras_pop  = accept && take_ok && is_jalr && rs1_link && (!rd_link || (rs1 != rd));
        top_idx  = ras_ptr - PTR_W'(1);
        pop_live = ras_pop && (ras_cnt != '0);
        ras_hit_d     = pop_live && (ras_mem[top_idx] == target);
        ptr_after_pop = pop_live ? top_idx : ras_ptr;
        cnt_after_pop = pop_live ? (ras_cnt - CNT_W'(1)) : ras_cnt;
    end

    // Pop-then-push collapses to overwriting the top entry in a single cycle.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (ras_push) begin
            ras_ptr <= ptr_after_pop + PTR_W'(1);
            ras_cnt <= (cnt_after_pop == CNT_W'(RAS_DEPTH)) ? cnt_after_pop
                                                             : cnt_after_pop + CNT_W'(1);
        end else begin
            ras_ptr <= ptr_after_pop;
            ras_cnt <= cnt_after_pop;
        end
    end

    always_ff @(posedge i_clock) begin
        if (ras_push) begin
            ras_mem[ptr_after_pop] <= link;
        end
    end
`else
    assign ras_hit_d = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_valid        <= 1'b0;
            o_branch_taken <= 1'b0;
            o_branch_addr  <= '0;
            o_ret_addr     <= '0;
            o_wr_retaddr   <= 1'b0;
            o_rd_retaddr   <= '0;
            o_misaligned   <= 1'b0;
            o_ras_hit      <= 1'b0;
            flush_cnt      <= 4'd0;
        end else begin
            o_valid        <= accept;
            o_branch_taken <= accept && take_ok;
            o_branch_addr  <= (accept && taken_raw) ? target : '0;
            o_ret_addr     <= (accept && take_ok && (is_jal || is_jalr)) ? link : '0;
            o_wr_retaddr   <= accept && take_ok && (is_jal || is_jalr) && (rd != 5'd0);
            o_rd_retaddr   <= (accept && take_ok && (is_jal || is_jalr)) ? NB_OPERAND'(rd) : '0;
            o_misaligned   <= accept && taken_raw && target[1];
            o_ras_hit      <= ras_hit_d;
            if (accept && take_ok) begin
                flush_cnt <= 4'(FLUSH_CYCLES);
            end else if (flush_cnt != 4'd0) begin
                flush_cnt <= flush_cnt - 4'd1;
            end
        end
    end

endmodule
